// File: rtl/seg_scan_driver.sv
// N-digit multiplexed 7-segment driver: sequential binary-to-BCD conversion,
// leading-zero blanking, per-digit dots, PWM brightness and overflow dashes.
module seg_scan_driver #(
    parameter int N_DIG       = 4,
    parameter int BIN_W       = 14,
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int ACT_LOW_SEG = 1,
    parameter int ACT_LOW_DIG = 1
) (
    input  logic             FPGA_CLK,
    input  logic             rst_butt,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    input  logic             lzb_en,
    input  logic [N_DIG-1:0] dot_mask,
    input  logic [3:0]       bright,
    output logic             ovf,
    output logic [6:0]       seg,
    output logic             dot,
    output logic [N_DIG-1:0] dig_en
);

    localparam int DIV    = CLK_HZ / SCAN_HZ;
    localparam int PH_DIV = DIV / 16;
    localparam int PRE_W  = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
    localparam int IDX_W  = $clog2(N_DIG);
    localparam int CNT_W  = $clog2(BIN_W);
    localparam int BCD_W  = 4 * N_DIG;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]      LIMIT   = pow10(N_DIG);
    localparam logic [6:0]       SEG_OFF = (ACT_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic             DOT_OFF = (ACT_LOW_SEG != 0);
    localparam logic [N_DIG-1:0] DIG_OFF = (ACT_LOW_DIG != 0) ? '1 : '0;

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < N_DIG; i++)
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        return r;
    endfunction

    // Active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0: seg_decode = 7'h3F;
            4'd1: seg_decode = 7'h06;
            4'd2: seg_decode = 7'h5B;
            4'd3: seg_decode = 7'h4F;
            4'd4: seg_decode = 7'h66;
            4'd5: seg_decode = 7'h6D;
            4'd6: seg_decode = 7'h7D;
            4'd7: seg_decode = 7'h07;
            4'd8: seg_decode = 7'h7F;
            4'd9: seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t           state_q;
    logic             busy_q, ovf_q, ovf_pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIN_W-1:0] sh_q;
    logic [BCD_W-1:0] bcd_q, bcd_adj_d, disp_q;

    assign bcd_adj_d = dabble_adj(bcd_q);

    always_ff @(posedge FPGA_CLK or posedge rst_butt) begin
        if (rst_butt) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (load) begin
                    state_q <= S_CONV;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                end
                S_CONV: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_q  <= bcd_q;
                    ovf_q   <= ovf_pend_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Upper BCD digits beyond N_DIG fall off the top; overflow is decided from the binary value instead.
    always_ff @(posedge FPGA_CLK) begin
        if (state_q == S_IDLE && load) begin
            sh_q       <= bin_in;
            bcd_q      <= '0;
            ovf_pend_q <= (64'(bin_in) >= LIMIT);
        end else if (state_q == S_CONV) begin
            sh_q  <= sh_q << 1;
            bcd_q <= {bcd_adj_d[BCD_W-2:0], sh_q[BIN_W-1]};
        end
    end

    logic [PRE_W-1:0] pre_q;
    logic [3:0]       phase_q;
    logic [IDX_W-1:0] idx_q;
    logic             tick;

    assign tick = (pre_q == PRE_W'(PH_DIV - 1));

    always_ff @(posedge FPGA_CLK or posedge rst_butt) begin
        if (rst_butt) begin
            pre_q   <= '0;
            phase_q <= 4'd0;
            idx_q   <= '0;
        end else if (tick) begin
            pre_q   <= '0;
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15)
                idx_q <= (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    logic [N_DIG-1:0] blank_d, dig_on_d;
    logic [3:0]       nib_d;
    logic             cur_blank_d, cur_dot_d, lit_d, dot_on_d, hi_zero;
    logic [6:0]       seg_on_d;

    always_comb begin
        blank_d     = '0;
        hi_zero     = lzb_en;
        nib_d       = 4'd0;
        cur_blank_d = 1'b0;
        cur_dot_d   = 1'b0;
        dig_on_d    = '0;
        // Digit 0 is never blanked so a zero value still shows '0'.
        for (int i = N_DIG - 1; i >= 1; i--) begin
            hi_zero    = hi_zero & (disp_q[4*i +: 4] == 4'd0);
            blank_d[i] = hi_zero;
        end
        lit_d = (phase_q < bright);
        for (int i = 0; i < N_DIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_d       = disp_q[4*i +: 4];
                cur_blank_d = blank_d[i];
                cur_dot_d   = dot_mask[i];
                dig_on_d[i] = lit_d;
            end
        end
        if (ovf_q)            seg_on_d = 7'h40;
        else if (cur_blank_d) seg_on_d = 7'h00;
        else                  seg_on_d = seg_decode(nib_d);
        dot_on_d = cur_dot_d;
        if (!lit_d) begin
            seg_on_d = 7'h00;
            dot_on_d = 1'b0;
        end
    end

    logic [6:0]       seg_q;
    logic             dot_q;
    logic [N_DIG-1:0] dig_q;

    always_ff @(posedge FPGA_CLK or posedge rst_butt) begin
        if (rst_butt) begin
            seg_q <= SEG_OFF;
            dot_q <= DOT_OFF;
            dig_q <= DIG_OFF;
        end else begin
            seg_q <= seg_on_d ^ SEG_OFF;
            dot_q <= dot_on_d ^ DOT_OFF;
            dig_q <= dig_on_d ^ DIG_OFF;
        end
    end

    assign busy   = busy_q;
    assign ovf    = ovf_q;
    assign seg    = seg_q;
    assign dot    = dot_q;
    assign dig_en = dig_q;

endmodule
